// File: rtl/ahb_master_request_gen_pkg.sv
// Shared types and helpers for the AHB master request/burst generator.
//   htrans_type / hburst_type : AHB transfer and burst encodings
//   beat_limit()              : last beat index (beats-1) of a burst
//   wrap_mask()               : wrap-boundary mask for WRAPx bursts, 0 otherwise
package ahb_master_request_gen_pkg;

   localparam int unsigned HTRANS_W  = 2;
   localparam int unsigned HBURST_W  = 3;
   localparam int unsigned LEN_W     = 4;
   localparam int unsigned MASK_W    = 6;
   localparam int unsigned ADDR_STEP = 4;

   typedef enum logic [HTRANS_W-1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_type;

   typedef enum logic [HBURST_W-1:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } hburst_type;

   // Index of the final beat; len only matters for undefined-length INCR.
   function automatic logic [LEN_W-1:0] beat_limit(input hburst_type burst,
                                                   input logic [LEN_W-1:0] len);
      logic [LEN_W-1:0] lim;
      case (burst)
         SINGLE:       lim = '0;
         INCR:         lim = len;
         WRAP4, INCR4: lim = LEN_W'(3);
         WRAP8, INCR8: lim = LEN_W'(7);
         default:      lim = LEN_W'(15);
      endcase
      return lim;
   endfunction

   // Byte-offset bits that wrap: 16/32/64-byte boundaries for 4-byte beats.
   function automatic logic [MASK_W-1:0] wrap_mask(input hburst_type burst);
      logic [MASK_W-1:0] m;
      case (burst)
         WRAP4:   m = MASK_W'(6'h0F);
         WRAP8:   m = MASK_W'(6'h1F);
         WRAP16:  m = MASK_W'(6'h3F);
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ahb_master_request_gen_if.sv
// Command + AHB address-phase bundle between the master core/arbiters and
// the request generator.
//   master modport : the request generator side
//   slave  modport : the core/arbiter side driving commands and grants
interface ahb_master_request_gen_if
   import ahb_master_request_gen_pkg::*;
#(
   parameter int unsigned SLAVE_NUM  = 4,
   parameter int unsigned ADDR_WIDTH = 32
) ();

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   hburst_type            cmd_burst;
   logic [LEN_W-1:0]      cmd_len;
   logic                  cmd_write;
   logic [SLAVE_NUM-1:0]  hgrant;
   logic                  hwait;
   logic [SLAVE_NUM-1:0]  hreq;
   logic [ADDR_WIDTH-1:0] haddr;
   htrans_type            htrans;
   hburst_type            hburst;
   logic                  hwrite;
   logic                  done;

   modport master (
      input  cmd_valid, cmd_addr, cmd_burst, cmd_len, cmd_write, hgrant, hwait,
      output cmd_ready, hreq, haddr, htrans, hburst, hwrite, done
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_burst, cmd_len, cmd_write, hgrant, hwait,
      input  cmd_ready, hreq, haddr, htrans, hburst, hwrite, done
   );

endinterface

// File: rtl/ahb_burst_addr_gen.sv
// Next beat address for incrementing and wrapping bursts (combinational).
//   addr        : current beat address
//   mask        : wrap mask from wrap_mask(); zero selects plain increment
//   next_addr_c : address of the following beat
module ahb_burst_addr_gen
   import ahb_master_request_gen_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [MASK_W-1:0]     mask,
   output logic [ADDR_WIDTH-1:0] next_addr_c
);

   logic [ADDR_WIDTH-1:0] inc_addr;
   logic [ADDR_WIDTH-1:0] wide_mask;

   // Wrap keeps the bits above the boundary and lets only the masked bits roll.
   always_comb begin
      inc_addr  = addr + ADDR_WIDTH'(ADDR_STEP);
      wide_mask = ADDR_WIDTH'(mask);
      if (mask == '0) begin
         next_addr_c = inc_addr;
      end else begin
         next_addr_c = (addr & ~wide_mask) | (inc_addr & wide_mask);
      end
   end

endmodule

// File: rtl/ahb_master_request_gen.sv
// Master-side request/burst generator: latches one burst command, requests
// the decoded slave's arbiter, then drives the address phase beat by beat.
//   hclk, hreset_n : bus clock, asynchronous active-low reset
//   bus (master)   : cmd_* handshake from the core, hgrant/hwait from the
//                    fabric; hreq/haddr/htrans/hburst/hwrite/done registered,
//                    cmd_ready decoded from state
module ahb_master_request_gen
   import ahb_master_request_gen_pkg::*;
#(
   parameter int unsigned SLAVE_NUM  = 4,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input logic                   hclk,
   input logic                   hreset_n,
   ahb_master_request_gen_if.master bus
);

   localparam int unsigned IDX_W = $clog2(SLAVE_NUM);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_BURST,
      ST_DATA
   } state_t;

   state_t                state;
   logic [IDX_W-1:0]      idx;
   logic [LEN_W-1:0]      beat_cnt;
   logic [LEN_W-1:0]      last_beat;
   logic [MASK_W-1:0]     mask;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  granted;

   assign granted       = bus.hgrant[idx];
   assign bus.cmd_ready = (state == ST_IDLE);

   ahb_burst_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .addr        (bus.haddr),
      .mask        (mask),
      .next_addr_c (next_addr)
   );

   // Request/burst sequencer; haddr doubles as the beat address register.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state      <= ST_IDLE;
         idx        <= '0;
         beat_cnt   <= '0;
         last_beat  <= '0;
         mask       <= '0;
         bus.hreq   <= '0;
         bus.haddr  <= '0;
         bus.htrans <= IDLE;
         bus.hburst <= SINGLE;
         bus.hwrite <= 1'b0;
         bus.done   <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  idx        <= bus.cmd_addr[ADDR_WIDTH-1 -: IDX_W];
                  beat_cnt   <= '0;
                  last_beat  <= beat_limit(bus.cmd_burst, bus.cmd_len);
                  mask       <= wrap_mask(bus.cmd_burst);
                  bus.haddr  <= bus.cmd_addr;
                  bus.hburst <= bus.cmd_burst;
                  bus.hwrite <= bus.cmd_write;
                  bus.hreq   <= SLAVE_NUM'(1) << bus.cmd_addr[ADDR_WIDTH-1 -: IDX_W];
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               // First beat after (re)grant is always NONSEQ at the held address.
               if (granted) begin
                  bus.htrans <= NONSEQ;
                  state      <= ST_BURST;
               end
            end
            ST_BURST: begin
               // hgrant is pre-gated by ~hwait, so only act on non-stall cycles.
               if (!bus.hwait) begin
                  if (!granted) begin
                     bus.htrans <= IDLE;
                     state      <= ST_REQ;
                  end else if (beat_cnt == last_beat) begin
                     bus.htrans <= IDLE;
                     bus.hreq   <= '0;
                     state      <= ST_DATA;
                  end else begin
                     beat_cnt   <= beat_cnt + LEN_W'(1);
                     bus.haddr  <= next_addr;
                     bus.htrans <= SEQ;
                  end
               end
            end
            ST_DATA: begin
               if (!bus.hwait) begin
                  bus.done <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
